// File: rtl/gsm_event_sequencer.sv
// Command front-end for the game state manager: queues hit/miss events, latches button
// requests and terminal conditions, and issues them one flag/trig transaction at a time.
module gsm_event_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_STAGE      = 3,
    parameter int GAP_CYCLES     = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk_1mhz,
    input  logic       rst,
    input  logic       hit,
    input  logic       miss,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic [2:0] state,
    input  logic [1:0] stage,
    input  logic [1:0] lives,
    input  logic [6:0] timer,
    input  logic       timer_running,
    input  logic       done,
    output logic [3:0] flag,
    output logic       trig,
    output logic       busy,
    output logic [3:0] fifo_level,
    output logic       overflow,
    output logic       timeout_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [2:0] ST_READY    = 3'b001;
    localparam logic [2:0] ST_PLAY     = 3'b010;
    localparam logic [2:0] ST_OVER     = 3'b011;
    localparam logic [2:0] ST_STG_CLR  = 3'b100;
    localparam logic [2:0] ST_GAME_CLR = 3'b101;

    localparam logic [3:0] CMD_HIT       = 4'b0001;
    localparam logic [3:0] CMD_MISS      = 4'b0010;
    localparam logic [3:0] CMD_PAUSE     = 4'b0100;
    localparam logic [3:0] CMD_RESUME    = 4'b0101;
    localparam logic [3:0] CMD_NEXT_STG  = 4'b1000;
    localparam logic [3:0] CMD_PLAY      = 4'b1010;
    localparam logic [3:0] CMD_STG_CLR   = 4'b1100;
    localparam logic [3:0] CMD_GAME_OVER = 4'b1101;
    localparam logic [3:0] CMD_GAME_CLR  = 4'b1110;
    localparam logic [3:0] CMD_RESET     = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} seq_state_t;

    seq_state_t    fsm_q, fsm_d;
    logic [3:0]    cmd_q, cmd_d, flag_d;
    logic          trig_d, tmo_d;
    logic [TW-1:0] wait_cnt, wait_d;
    logic [GW-1:0] gap_cnt, gap_d;
    logic          start_pend, pause_pend, paused;
    logic          start_pend_d, pause_pend_d, paused_d;
    logic          sel, pop, start_issued, pause_issued;
    logic          in_play, start_ok, start_req, pause_req, terminal_ok;

    logic [3:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [3:0]    count;
    logic          full, one_left, push_hit, push_miss, drop;

    logic          unused_timer_running;
    assign unused_timer_running = timer_running;

    assign in_play     = (state == ST_PLAY);
    assign start_ok    = (state == ST_READY) || (state == ST_STG_CLR) ||
                         (state == ST_OVER)  || (state == ST_GAME_CLR);
    assign start_req   = start_pend | start_btn;
    assign pause_req   = pause_pend | pause_btn;
    assign terminal_ok = in_play && !paused;

    // A simultaneous hit+miss needs two free slots; the hit always wins the last one.
    assign full      = (count == 4'(FIFO_DEPTH));
    assign one_left  = (count == 4'(FIFO_DEPTH - 1));
    assign push_hit  = in_play && hit && !full;
    assign push_miss = in_play && miss && (hit ? !(full || one_left) : !full);
    assign drop      = in_play && ((hit && !push_hit) || (miss && !push_miss));

    always_comb begin
        fsm_d        = fsm_q;
        cmd_d        = cmd_q;
        flag_d       = flag;
        trig_d       = trig;
        wait_d       = wait_cnt;
        gap_d        = gap_cnt;
        tmo_d        = 1'b0;
        sel          = 1'b1;
        pop          = 1'b0;
        start_issued = 1'b0;
        pause_issued = 1'b0;
        paused_d     = paused && in_play;
        case (fsm_q)
            S_IDLE: begin
                if (terminal_ok && lives == 2'd0) begin
                    cmd_d = CMD_GAME_OVER;
                end else if (terminal_ok && timer == 7'd0 && stage == 2'(MAX_STAGE)) begin
                    cmd_d = CMD_GAME_CLR;
                end else if (terminal_ok && timer == 7'd0) begin
                    cmd_d = CMD_STG_CLR;
                end else if (start_req && state == ST_READY) begin
                    cmd_d        = CMD_PLAY;
                    start_issued = 1'b1;
                end else if (start_req && state == ST_STG_CLR) begin
                    cmd_d        = CMD_NEXT_STG;
                    start_issued = 1'b1;
                end else if (start_req && (state == ST_OVER || state == ST_GAME_CLR)) begin
                    cmd_d        = CMD_RESET;
                    start_issued = 1'b1;
                end else if (pause_req && in_play) begin
                    cmd_d        = paused ? CMD_RESUME : CMD_PAUSE;
                    paused_d     = !paused;
                    pause_issued = 1'b1;
                end else if (in_play && count != 4'd0) begin
                    cmd_d = fifo_mem[rd_ptr];
                    pop   = 1'b1;
                end else begin
                    sel = 1'b0;
                end
                if (sel) fsm_d = S_ISSUE;
            end
            S_ISSUE: begin
                flag_d = cmd_q;
                trig_d = 1'b1;
                wait_d = '0;
                fsm_d  = S_WAIT;
            end
            S_WAIT: begin
                if (done) begin
                    trig_d = 1'b0;
                    gap_d  = '0;
                    fsm_d  = S_GAP;
                end else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    trig_d = 1'b0;
                    tmo_d  = 1'b1;
                    gap_d  = '0;
                    fsm_d  = S_GAP;
                end else begin
                    wait_d = wait_cnt + TW'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) fsm_d = S_IDLE;
                else gap_d = gap_cnt + GW'(1);
            end
            default: fsm_d = S_IDLE;
        endcase
        // Requests survive a busy sequencer but die once the game state no longer allows them.
        start_pend_d = start_req && start_ok && !start_issued;
        pause_pend_d = pause_req && in_play && !pause_issued;
    end

    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            cmd_q       <= '0;
            flag        <= '0;
            trig        <= 1'b0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
            start_pend  <= 1'b0;
            pause_pend  <= 1'b0;
            paused      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cmd_q       <= cmd_d;
            flag        <= flag_d;
            trig        <= trig_d;
            wait_cnt    <= wait_d;
            gap_cnt     <= gap_d;
            timeout_err <= tmo_d;
            start_pend  <= start_pend_d;
            pause_pend  <= pause_pend_d;
            paused      <= paused_d;
        end
    end

    // Leaving play discards everything queued, so stale hits never reach a new round.
    always_ff @(posedge clk_1mhz) begin
        if (rst || !in_play) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_hit) fifo_mem[wr_ptr] <= CMD_HIT;
            if (push_miss) fifo_mem[push_hit ? wr_ptr + PW'(1) : wr_ptr] <= CMD_MISS;
            wr_ptr <= wr_ptr + PW'(push_hit) + PW'(push_miss);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + 4'(push_hit) + 4'(push_miss) - 4'(pop);
        end
    end

    always_ff @(posedge clk_1mhz) begin
        if (rst) overflow <= 1'b0;
        else     overflow <= drop;
    end

    assign busy       = (fsm_q != S_IDLE);
    assign fifo_level = count;

endmodule
